// File: rtl/turn_input_conditioner_pkg.sv
// Shared types and default parameters for the turn-switch input conditioner.
// The pairing FSM state encoding is defined here so it appears the same wherever it is used.
package turn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } cond_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PAIR_WINDOW     = 8;
    localparam int DEF_TICK_DIV        = 4;

endpackage

// File: rtl/turn_input_conditioner_debounce_sync.sv
// Synchroniser chain followed by a debounce filter for one raw switch input.
// The stable value only follows the synchronised input after DEBOUNCE_CYCLES of continuous disagreement.
module debounce_sync
    import turn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_x;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_x = sync_q[SYNC_STAGES-1];

    // A single agreeing cycle clears the count, so short bounce never reaches db.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_x != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_x;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Turn-switch front end: debounced left/right inputs, press pairing into hazard requests,
// and a free-running tick enable that paces the downstream tail-light sequencer.
module turn_input_conditioner
    import turn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PAIR_WINDOW     = DEF_PAIR_WINDOW,
    parameter int TICK_DIV        = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left_out,
    output logic right_out,
    output logic tick,
    output logic busy
);

    localparam int WW = (PAIR_WINDOW > 1) ? $clog2(PAIR_WINDOW) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [WW-1:0] WIN_LAST  = WW'(PAIR_WINDOW - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic db_l, db_r;

    debounce_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk  (clk),
        .reset(reset),
        .raw  (left_raw),
        .db   (db_l)
    );

    debounce_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk  (clk),
        .reset(reset),
        .raw  (right_raw),
        .db   (db_r)
    );

    cond_state_t   state_q;
    logic [WW-1:0] win_cnt_q;
    logic          left_q, right_q, busy_q;

    // A lone press waits in PEND for its partner; outputs are only driven in ACTIVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    left_q  <= 1'b0;
                    right_q <= 1'b0;
                    if (db_l && db_r) begin
                        state_q <= ACTIVE;
                        left_q  <= 1'b1;
                        right_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (db_l ^ db_r) begin
                        state_q   <= PEND;
                        win_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                PEND: begin
                    win_cnt_q <= win_cnt_q + WW'(1);
                    if (db_l && db_r) begin
                        state_q <= ACTIVE;
                        left_q  <= 1'b1;
                        right_q <= 1'b1;
                    end else if (!db_l && !db_r) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        state_q <= ACTIVE;
                        left_q  <= db_l;
                        right_q <= db_r;
                    end
                end
                ACTIVE: begin
                    if (!db_l && !db_r) begin
                        state_q <= IDLE;
                        left_q  <= 1'b0;
                        right_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        left_q  <= db_l;
                        right_q <= db_r;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    left_q  <= 1'b0;
                    right_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [TW-1:0] tick_cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
            tick_q     <= (tick_cnt_q == TICK_LAST);
        end
    end

    assign left_out  = left_q;
    assign right_out = right_q;
    assign busy      = busy_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner with hand-derived edge latencies.
// A second instance with a long pairing window exercises the aborted-press path.
module tb_turn_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic left_out, right_out, tick, busy;
    logic w_left_out, w_right_out, w_tick, w_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    turn_input_conditioner dut (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .left_out (left_out),
        .right_out(right_out),
        .tick     (tick),
        .busy     (busy)
    );

    turn_input_conditioner #(.PAIR_WINDOW(32)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .left_out (w_left_out),
        .right_out(w_right_out),
        .tick     (w_tick),
        .busy     (w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int k);
        left_raw  = 1'b0;
        right_raw = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({left_out, right_out, tick, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=0000", {left_out, right_out, tick, busy});
        end
        n_cmp++;
        if ({w_left_out, w_right_out, w_tick, w_busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs_w got=%b exp=0000", {w_left_out, w_right_out, w_tick, w_busy});
        end
        reset = 1'b0;
        settle(10);
    endtask

    task automatic test_single_press();
        left_raw = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            n_cmp++;
            if ({left_out, right_out, busy} !== {(n >= 27), 1'b0, (n >= 19)}) begin
                n_bad++;
                $display("FAIL single_press edge=%0d got l/r/busy=%b%b%b exp=%b%b%b",
                         n, left_out, right_out, busy, (n >= 27), 1'b0, (n >= 19));
            end
        end
        left_raw = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_cmp++;
            if ({left_out, right_out, busy} !== {(n < 19), 1'b0, (n < 19)}) begin
                n_bad++;
                $display("FAIL release edge=%0d got l/r/busy=%b%b%b exp=%b%b%b",
                         n, left_out, right_out, busy, (n < 19), 1'b0, (n < 19));
            end
        end
        settle(10);
    endtask

    task automatic test_simultaneous();
        left_raw  = 1'b1;
        right_raw = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_cmp++;
            if ({left_out, right_out} !== {2{n >= 19}}) begin
                n_bad++;
                $display("FAIL simultaneous edge=%0d got l/r=%b%b exp=%b%b",
                         n, left_out, right_out, (n >= 19), (n >= 19));
            end
        end
        left_raw  = 1'b0;
        right_raw = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_cmp++;
            if ({left_out, right_out, busy} !== {3{n < 19}}) begin
                n_bad++;
                $display("FAIL simul_release edge=%0d got l/r/busy=%b%b%b exp=%b",
                         n, left_out, right_out, busy, {3{n < 19}});
            end
        end
        settle(10);
    endtask

    task automatic test_staggered();
        left_raw = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 3) right_raw = 1'b1;
            n_cmp++;
            if ({left_out, right_out} !== {2{n >= 22}}) begin
                n_bad++;
                $display("FAIL staggered edge=%0d got l/r=%b%b exp=%b%b",
                         n, left_out, right_out, (n >= 22), (n >= 22));
            end
        end
        settle(50);
    endtask

    task automatic test_bounce();
        left_raw = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n < 40 && (n % 5) == 0) left_raw = ~left_raw;
            if (n == 40) left_raw = 1'b0;
            n_cmp++;
            if ({left_out, right_out, busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL bounce edge=%0d got l/r/busy=%b%b%b exp=000",
                         n, left_out, right_out, busy);
            end
        end
        settle(10);
    endtask

    task automatic test_abort();
        logic exp_busy_w, exp_l;
        left_raw = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 20) left_raw = 1'b0;
            exp_busy_w = (n >= 19) && (n < 39);
            exp_l      = (n >= 27) && (n < 39);
            n_cmp++;
            if ({w_left_out, w_right_out, w_busy} !== {2'b00, exp_busy_w}) begin
                n_bad++;
                $display("FAIL abort_window edge=%0d got l/r/busy=%b%b%b exp=00%b",
                         n, w_left_out, w_right_out, w_busy, exp_busy_w);
            end
            n_cmp++;
            if ({left_out, busy} !== {exp_l, exp_busy_w}) begin
                n_bad++;
                $display("FAIL short_press edge=%0d got l/busy=%b%b exp=%b%b",
                         n, left_out, busy, exp_l, exp_busy_w);
            end
        end
        settle(10);
    endtask

    task automatic test_reset_tick();
        left_raw = 1'b1;
        for (int n = 1; n <= 22; n++) step();
        n_cmp++;
        if ({busy, left_out} !== 2'b10) begin
            n_bad++;
            $display("FAIL pend_before_reset got busy/l=%b%b exp=10", busy, left_out);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({left_out, right_out, tick, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=0000", {left_out, right_out, tick, busy});
        end
        left_raw = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            step();
            n_cmp++;
            if ({tick, w_tick, busy} !== {{2{(n % 4) == 0}}, 1'b0}) begin
                n_bad++;
                $display("FAIL tick edge=%0d got tick/tick_w/busy=%b%b%b exp=%b%b0",
                         n, tick, w_tick, busy, ((n % 4) == 0), ((n % 4) == 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_staggered();
        test_bounce();
        test_abort();
        test_reset_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
